// File: rtl/oled_char_buffer.sv
// oled_char_buffer: 4x16 character screen with direct/append write port, registered refresh reads and dirty flag.
// Optional macro OLED_CHAR_BUF_SCROLL_EN scrolls the screen up one row instead of wrapping the cursor.
module oled_char_buffer #(
    parameter logic [7:0] BLANK = 8'h20,
    parameter int         ROWS  = 4,
    parameter int         COLS  = 16
) (
    input  logic       sysclk,
    input  logic       rstd,
    input  logic       we,
    input  logic [5:0] waddr,
    input  logic [7:0] wdata,
    input  logic       rd_en,
    input  logic [5:0] rd_addr,
    input  logic       frame_done,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic [5:0] cursor,
    output logic       dirty
);
    localparam logic [1:0] S_CLEAR  = 2'd0;
    localparam logic [1:0] S_IDLE   = 2'd1;
    localparam logic [1:0] S_SCROLL = 2'd2;
    localparam logic [5:0] LAST     = 6'(ROWS * COLS - 1);
    localparam logic [5:0] APPEND   = 6'd63;

    logic [1:0] state_q, state_d;
    logic [5:0] ptr_q, ptr_d;
    logic [5:0] cursor_q, cursor_d;
    logic       dirty_q, dirty_d;
    logic [7:0] rd_data_q;
    logic       rd_valid_q;
    logic [7:0] mem [64];

    logic       idle, app, dir_wr, app_nl, app_ff, app_bs, app_chr, last_row, sweep_done;
    logic       mem_we;
    logic [5:0] mem_wa;
    logic [7:0] mem_wd;
    logic [5:0] nl_cursor, chr_cursor;

    assign idle     = state_q == S_IDLE;
    assign app      = idle && we && waddr == APPEND;
    assign dir_wr   = idle && we && waddr != APPEND;
    assign app_nl   = app && wdata == 8'h0A;
    assign app_ff   = app && wdata == 8'h0C;
    assign app_bs   = app && wdata == 8'h08;
    assign app_chr  = app && !(app_nl || app_ff || app_bs);
    assign last_row = cursor_q[5:4] == 2'd3;

`ifdef OLED_CHAR_BUF_SCROLL_EN
    logic scroll_go;
    // The bottom row is reused after a scroll, so the cursor lands at its start.
    assign scroll_go  = (app_nl && last_row) || (app_chr && cursor_q == LAST);
    assign nl_cursor  = last_row ? 6'd48 : {cursor_q[5:4] + 2'd1, 4'h0};
    assign chr_cursor = cursor_q == LAST ? 6'd48 : cursor_q + 6'd1;
    assign mem_wd     = state_q == S_SCROLL ? (ptr_q < 6'd48 ? mem[ptr_q + 6'(COLS)] : BLANK)
                      : !idle ? BLANK : wdata;
`else
    assign nl_cursor  = {cursor_q[5:4] + 2'd1, 4'h0};
    assign chr_cursor = cursor_q + 6'd1;
    assign mem_wd     = !idle ? BLANK : wdata;
`endif

    assign mem_we = !idle || dir_wr || app_chr;
    assign mem_wa = !idle ? ptr_q : dir_wr ? waddr : cursor_q;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        sweep_done = 1'b0;
        if (!idle) begin
            ptr_d = ptr_q + 6'd1;
            if (ptr_q == LAST) begin
                state_d    = S_IDLE;
                sweep_done = 1'b1;
            end
        end else if (app_ff) begin
            state_d = S_CLEAR;
            ptr_d   = 6'd0;
`ifdef OLED_CHAR_BUF_SCROLL_EN
        end else if (scroll_go) begin
            state_d = S_SCROLL;
            ptr_d   = 6'd0;
`endif
        end
    end

    assign cursor_d = app_nl  ? nl_cursor
                    : app_ff  ? 6'd0
                    : app_bs  ? (cursor_q == 6'd0 ? 6'd0 : cursor_q - 6'd1)
                    : app_chr ? chr_cursor
                    : cursor_q;

    // A completed sweep and a cell write both outrank a same-cycle frame_done.
    assign dirty_d = (dir_wr || app_chr || sweep_done) ? 1'b1 : frame_done ? 1'b0 : dirty_q;

    always_ff @(posedge sysclk or negedge rstd) begin
        if (!rstd) begin
            state_q    <= S_CLEAR;
            ptr_q      <= 6'd0;
            cursor_q   <= 6'd0;
            dirty_q    <= 1'b0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cursor_q   <= cursor_d;
            dirty_q    <= dirty_d;
            rd_valid_q <= rd_en;
            if (rd_en) rd_data_q <= mem[rd_addr];
        end
    end

    always_ff @(posedge sysclk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign busy     = !idle;
    assign cursor   = cursor_q;
    assign dirty    = dirty_q;
endmodule

// File: tb/tb_oled_char_buffer.sv
// tb_oled_char_buffer: randomized and directed checks of oled_char_buffer against a transaction-level screen model.
module tb_oled_char_buffer;
    logic       sysclk = 1'b0;
    logic       rstd = 1'b0;
    logic       we = 1'b0;
    logic [5:0] waddr = 6'd0;
    logic [7:0] wdata = 8'h00;
    logic       rd_en = 1'b0;
    logic [5:0] rd_addr = 6'd0;
    logic       frame_done = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;
    logic [5:0] cursor;
    logic       dirty;

    oled_char_buffer dut (
        .sysclk(sysclk), .rstd(rstd), .we(we), .waddr(waddr), .wdata(wdata),
        .rd_en(rd_en), .rd_addr(rd_addr), .frame_done(frame_done),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .cursor(cursor), .dirty(dirty)
    );

    always #5 sysclk = ~sysclk;

    logic [7:0] m_mem [64];
    int         m_left;
    int         m_cur;
    bit         m_dirty, m_rv;
    logic [7:0] m_rd;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Screen semantics: a sweep blanks one cell per cycle for 64 cycles; otherwise one write transaction.
    task automatic model_step();
        bit set = 0;
        if (rd_en) m_rd = m_mem[rd_addr];
        m_rv = rd_en;
        if (m_left > 0) begin
            m_mem[64 - m_left] = 8'h20;
            m_left--;
            if (m_left == 0) set = 1;
        end else if (we && waddr != 6'd63) begin
            m_mem[waddr] = wdata;
            set = 1;
        end else if (we) begin
            if (wdata == 8'h0A) m_cur = ((m_cur / 16 + 1) % 4) * 16;
            else if (wdata == 8'h0C) begin m_cur = 0; m_left = 64; end
            else if (wdata == 8'h08) m_cur = m_cur > 0 ? m_cur - 1 : 0;
            else begin
                m_mem[m_cur] = wdata;
                m_cur = (m_cur + 1) % 64;
                set = 1;
            end
        end
        m_dirty = set ? 1'b1 : frame_done ? 1'b0 : m_dirty;
    endtask

    task automatic compare();
        chk("busy", 32'(busy), 32'(m_left > 0));
        chk("cursor", 32'(cursor), 32'(m_cur));
        chk("dirty", 32'(dirty), 32'(m_dirty));
        chk("rd_valid", 32'(rd_valid), 32'(m_rv));
        chk("rd_data", 32'(rd_data), 32'(m_rd));
    endtask

    task automatic step();
        @(posedge sysclk);
        if (rstd) model_step();
        #1 compare();
    endtask

    task automatic quiet();
        we = 0; rd_en = 0; frame_done = 0;
    endtask

    task automatic do_reset();
        quiet();
        rstd = 0;
        m_left = 64; m_cur = 0; m_dirty = 0; m_rv = 0; m_rd = 8'h00;
        #2 compare();
        repeat (2) step();
        rstd = 1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_left > 0 && n < 200) begin step(); n++; end
        chk("sweep_ends", 32'(busy), 32'd0);
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        we = 1; waddr = a; wdata = d;
        step();
        we = 0;
    endtask

    task automatic rd(input logic [5:0] a, input logic [7:0] exp, input string name);
        rd_en = 1; rd_addr = a;
        step();
        rd_en = 0;
        chk(name, 32'(rd_data), 32'(exp));
        chk("rd_pulse", 32'(rd_valid), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) m_mem[i] = 8'h00;
        do_reset();
        chk("reset_busy", 32'(busy), 32'd1);
        chk("reset_dirty", 32'(dirty), 32'd0);
        repeat (63) step();
        chk("busy_cycle64", 32'(busy), 32'd1);
        step();
        chk("idle_after_64", 32'(busy), 32'd0);
        chk("dirty_after_clear", 32'(dirty), 32'd1);
        for (int i = 0; i < 64; i++) rd(6'(i), 8'h20, "blank_cell");
        step();
        chk("rd_valid_drop", 32'(rd_valid), 32'd0);
        wr(6'd63, 8'h48);
        wr(6'd63, 8'h69);
        chk("append_cursor", 32'(cursor), 32'd2);
        rd(6'd0, 8'h48, "cell0_H");
        rd(6'd1, 8'h69, "cell1_i");
        wr(6'd5, 8'h41);
        chk("direct_cursor", 32'(cursor), 32'd2);
        rd(6'd5, 8'h41, "cell5_A");
        wr(6'd7, 8'h0C);
        chk("direct_ff_no_clear", 32'(busy), 32'd0);
        rd(6'd7, 8'h0C, "cell7_ctrl");
        wr(6'd63, 8'h0A);
        wr(6'd63, 8'h2E);
        chk("cursor17", 32'(cursor), 32'd17);
        wr(6'd63, 8'h0A);
        chk("nl_row2", 32'(cursor), 32'd32);
        wr(6'd63, 8'h0A);
        wr(6'd63, 8'h31);
        wr(6'd63, 8'h32);
        chk("cursor50", 32'(cursor), 32'd50);
        wr(6'd63, 8'h0A);
        chk("nl_wrap", 32'(cursor), 32'd0);
        for (int i = 0; i < 64; i++) wr(6'd63, 8'h61);
        chk("append_wrap", 32'(cursor), 32'd0);
        rd(6'd63, 8'h61, "cell63_a");
        wr(6'd63, 8'h0C);
        chk("ff_busy", 32'(busy), 32'd1);
        wr(6'd3, 8'h55);
        wait_idle();
        rd(6'd3, 8'h20, "dropped_write");
        chk("ff_cursor", 32'(cursor), 32'd0);
        wr(6'd63, 8'h08);
        chk("bs_saturate", 32'(cursor), 32'd0);
        frame_done = 1; step(); frame_done = 0;
        chk("frame_clears", 32'(dirty), 32'd0);
        frame_done = 1; wr(6'd10, 8'h33); frame_done = 0;
        chk("set_wins", 32'(dirty), 32'd1);
        wr(6'd9, 8'hAA);
        we = 1; waddr = 6'd9; wdata = 8'hBB; rd(6'd9, 8'hAA, "read_before_write"); we = 0;
        rd(6'd9, 8'hBB, "cell9_new");
        wr(6'd63, 8'h0C);
        repeat (10) step();
        do_reset();
        wait_idle();
        rd(6'd40, 8'h20, "restart_sweep");
        for (int c = 0; c < 4000; c++) begin
            int r = $urandom_range(0, 99);
            we = $urandom_range(0, 1) == 1;
            waddr = $urandom_range(0, 3) == 0 ? 6'd63 : 6'($urandom_range(0, 63));
            wdata = r < 10 ? 8'h0A : r < 12 ? 8'h0C : r < 20 ? 8'h08 : 8'($urandom_range(0, 255));
            rd_en = $urandom_range(0, 1) == 1;
            rd_addr = 6'($urandom_range(0, 63));
            frame_done = $urandom_range(0, 7) == 0;
            step();
        end
        quiet();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
